// File: rtl/frog_input_conditioner_if.sv
// Switch-to-move bundle between the raw direction switches and the frog game core.
// Latency: none (wires only).
// Backpressure: none; move pulses are fire-and-forget, the core must take them in the cycle they appear.
// Signals: SW1..SW4 raw async switches (Up, Down, Left, Right); MOVE_* single-cycle move pulses;
//          BTN_STATE debounced levels {SW4,SW3,SW2,SW1}.
interface frog_input_conditioner_if;
   logic       SW1;
   logic       SW2;
   logic       SW3;
   logic       SW4;
   logic       MOVE_UP;
   logic       MOVE_DOWN;
   logic       MOVE_LEFT;
   logic       MOVE_RIGHT;
   logic [3:0] BTN_STATE;

   // switch side drives levels and observes pulses
   modport master (
      output SW1, SW2, SW3, SW4,
      input  MOVE_UP, MOVE_DOWN, MOVE_LEFT, MOVE_RIGHT, BTN_STATE
   );

   // conditioner consumes levels and produces pulses
   modport slave (
      input  SW1, SW2, SW3, SW4,
      output MOVE_UP, MOVE_DOWN, MOVE_LEFT, MOVE_RIGHT, BTN_STATE
   );
endinterface

// File: rtl/frog_input_conditioner.sv
// Synchronises, debounces and arbitrates the four direction switches into single-cycle move pulses.
// Latency: raw edge -> BTN_STATE in DEBOUNCE_CYCLES+2 edges, -> first MOVE_* pulse in DEBOUNCE_CYCLES+3.
// Backpressure: none; at most one registered MOVE_* pulse per cycle, hold/auto-repeat paced by timers.
// Ports: CLK system clock; RST synchronous active-high reset; io (slave) carries SW1..SW4 in,
//        MOVE_UP/DOWN/LEFT/RIGHT pulses and BTN_STATE debounced levels out.
module frog_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int REPEAT_DELAY    = 12500000,
   parameter int REPEAT_PERIOD   = 5000000,
   parameter int REPEAT_EN       = 1,
   parameter int CNT_W           = 24
) (
   input  logic                    CLK,
   input  logic                    RST,
   frog_input_conditioner_if.slave io
);

   localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] TMR_MAX  = '1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      REPEAT = 2'd2
   } state_t;

   logic [3:0]       sw_raw;
   logic [3:0]       s1;
   logic [3:0]       s2;
   logic [3:0]       db;
   logic [CNT_W-1:0] cnt [4];

   state_t           state_q, state_d;
   logic [1:0]       dir_q, dir_d;
   logic [CNT_W-1:0] tmr_q, tmr_d;
   logic [3:0]       move_q, move_d;
   logic [1:0]       win;

   // bit index == direction code: 0 Up, 1 Down, 2 Left, 3 Right
   assign sw_raw = {io.SW4, io.SW3, io.SW2, io.SW1};

   // Synchroniser and per-switch debounce. The counter only runs while the
   // synced level disagrees with the debounced one, so any bounce back restarts it.
   always_ff @(posedge CLK) begin
      if (RST) begin
         s1 <= '0;
         s2 <= '0;
         db <= '0;
         for (int i = 0; i < 4; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         s1 <= sw_raw;
         s2 <= s1;
         for (int i = 0; i < 4; i++) begin
            if (s2[i] == db[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == DB_LAST) begin
               db[i]  <= s2[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_ONE;
            end
         end
      end
   end

   // Fixed priority Up > Down > Left > Right; only consulted from IDLE.
   always_comb begin
      win = 2'd0;
      casez (db)
         4'b???1: win = 2'd0;
         4'b??10: win = 2'd1;
         4'b?100: win = 2'd2;
         4'b1000: win = 2'd3;
         default: win = 2'd0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         dir_q   <= 2'd0;
         tmr_q   <= '0;
         move_q  <= '0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         tmr_q   <= tmr_d;
         move_q  <= move_d;
      end
   end

   // dir is frozen from the first pulse until its own button releases; other
   // buttons only get a look-in once the FSM is back in IDLE.
   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      tmr_d   = tmr_q;
      move_d  = '0;
      case (state_q)
         IDLE: begin
            if (|db) begin
               dir_d   = win;
               move_d  = 4'b0001 << win;
               tmr_d   = '0;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (!db[dir_q]) begin
               state_d = IDLE;
            end else if ((REPEAT_EN != 0) && (tmr_q == RD_LAST)) begin
               move_d  = 4'b0001 << dir_q;
               tmr_d   = '0;
               state_d = REPEAT;
            end else if (tmr_q != TMR_MAX) begin
               // saturate so a long hold with repeat disabled cannot wrap
               tmr_d = tmr_q + CNT_ONE;
            end
         end
         REPEAT: begin
            if (!db[dir_q]) begin
               state_d = IDLE;
            end else if (tmr_q == RP_LAST) begin
               move_d = 4'b0001 << dir_q;
               tmr_d  = '0;
            end else begin
               tmr_d = tmr_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign io.MOVE_UP    = move_q[0];
   assign io.MOVE_DOWN  = move_q[1];
   assign io.MOVE_LEFT  = move_q[2];
   assign io.MOVE_RIGHT = move_q[3];
   assign io.BTN_STATE  = db;

endmodule

// File: tb/tb_frog_input_conditioner.sv
module tb_frog_input_conditioner;

   localparam int DB = 4;
   localparam int RD = 10;
   localparam int RP = 5;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [3:0] sw  = 4'b0000;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int base  = 0;
   bit chk_en = 1'b0;

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc++;

   frog_input_conditioner_if ifa ();
   frog_input_conditioner_if ifb ();

   assign ifa.SW1 = sw[0];
   assign ifa.SW2 = sw[1];
   assign ifa.SW3 = sw[2];
   assign ifa.SW4 = sw[3];
   assign ifb.SW1 = sw[0];
   assign ifb.SW2 = sw[1];
   assign ifb.SW3 = sw[2];
   assign ifb.SW4 = sw[3];

   frog_input_conditioner #(
      .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_EN(1), .CNT_W(8)
   ) dut_a (
      .CLK(CLK), .RST(RST), .io(ifa.slave)
   );

   frog_input_conditioner #(
      .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_EN(0), .CNT_W(8)
   ) dut_b (
      .CLK(CLK), .RST(RST), .io(ifb.slave)
   );

   logic [3:0] mv_a, mv_b;
   assign mv_a = {ifa.MOVE_RIGHT, ifa.MOVE_LEFT, ifa.MOVE_DOWN, ifa.MOVE_UP};
   assign mv_b = {ifb.MOVE_RIGHT, ifb.MOVE_LEFT, ifb.MOVE_DOWN, ifb.MOVE_UP};

   // ---------------- reference model ----------------
   // Debounce: the debounced level adopts the synced level once that level has
   // been seen on DB consecutive edges while differing from it.
   // Movement: a press pulses immediately, then (repeat enabled) at RD edges
   // after the press and every RP edges after that, until its button releases.
   logic [3:0] m_s1, m_s2, m_db;
   logic       m_last [4];
   int         m_run  [4];
   int         m_held [2];
   int         m_t    [2];
   logic [3:0] m_move [2];
   int         rep_en [2] = '{1, 0};

   initial begin
      m_s1 = '0; m_s2 = '0; m_db = '0;
      for (int i = 0; i < 4; i++) begin m_last[i] = 1'b0; m_run[i] = 0; end
      for (int k = 0; k < 2; k++) begin m_held[k] = -1; m_t[k] = 0; m_move[k] = '0; end
   end

   always @(posedge CLK) begin
      logic [3:0] db_old;
      if (RST) begin
         m_s1 = '0; m_s2 = '0; m_db = '0;
         for (int i = 0; i < 4; i++) begin m_last[i] = 1'b0; m_run[i] = 0; end
         for (int k = 0; k < 2; k++) begin m_held[k] = -1; m_t[k] = 0; m_move[k] = '0; end
      end else begin
         db_old = m_db;
         for (int i = 0; i < 4; i++) begin
            if (m_s2[i] == m_last[i]) m_run[i]++;
            else begin m_run[i] = 1; m_last[i] = m_s2[i]; end
            if (m_s2[i] != m_db[i] && m_run[i] >= DB) m_db[i] = m_s2[i];
         end
         m_s2 = m_s1;
         m_s1 = sw;
         for (int k = 0; k < 2; k++) begin
            m_move[k] = '0;
            if (m_held[k] < 0) begin
               for (int d = 3; d >= 0; d--) if (db_old[d]) m_held[k] = d;
               if (m_held[k] >= 0) begin
                  m_t[k] = 0;
                  m_move[k][m_held[k]] = 1'b1;
               end
            end else if (!db_old[m_held[k]]) begin
               m_held[k] = -1;
            end else begin
               m_t[k]++;
               if (rep_en[k] != 0 && m_t[k] >= RD && ((m_t[k] - RD) % RP) == 0)
                  m_move[k][m_held[k]] = 1'b1;
            end
         end
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %0d, expected %0d", nm, cyc, act, exp);
      end
   endtask

   int la_e[$], la_d[$], lb_e[$], lb_d[$];

   function automatic int dir_of(input logic [3:0] m);
      int r;
      r = -1;
      case (m)
         4'b0001: r = 0;
         4'b0010: r = 1;
         4'b0100: r = 2;
         4'b1000: r = 3;
         default: r = -1;
      endcase
      return r;
   endfunction

   always @(negedge CLK) begin
      if (chk_en) begin
         chk("move_a", int'(mv_a), int'(m_move[0]));
         chk("move_b", int'(mv_b), int'(m_move[1]));
         chk("btn_a", int'(ifa.BTN_STATE), int'(m_db));
         chk("btn_b", int'(ifb.BTN_STATE), int'(m_db));
         if (mv_a != 0) begin la_e.push_back(cyc - base); la_d.push_back(dir_of(mv_a)); end
         if (mv_b != 0) begin lb_e.push_back(cyc - base); lb_d.push_back(dir_of(mv_b)); end
      end
   end

   // literal pulse log pins: first n entries (edge, direction) of DUT k
   task automatic chk_log(input string nm, input int k, input int n, input int ee[4], input int dd[4]);
      int e[$], d[$];
      if (k == 0) begin e = la_e; d = la_d; end
      else        begin e = lb_e; d = lb_d; end
      chk({nm, "_count"}, e.size(), n);
      for (int i = 0; i < n && i < e.size(); i++) begin
         chk($sformatf("%s_edge%0d", nm, i), e[i], ee[i]);
         chk($sformatf("%s_dir%0d", nm, i), d[i], dd[i]);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic start();
      la_e.delete(); la_d.delete(); lb_e.delete(); lb_d.delete();
      base = cyc;
   endtask

   task automatic pulse_reset();
      sw  = '0;
      RST = 1'b1;
      step(2);
      RST = 1'b0;
      step(2);
   endtask

   initial begin
      step(3);
      chk_en = 1'b1;
      chk("reset_move_a", int'(mv_a), 0);
      chk("reset_btn_a", int'(ifa.BTN_STATE), 0);
      RST = 1'b0;
      step(2);

      // 1: 3-cycle glitch never reaches the debounced level
      start();
      sw[0] = 1'b1; step(3); sw[0] = 1'b0; step(15);
      chk_log("glitch_a", 0, 0, '{0, 0, 0, 0}, '{0, 0, 0, 0});
      chk("glitch_btn", int'(ifa.BTN_STATE), 0);

      // 2: long hold of Up: press, delay, repeat
      pulse_reset(); start();
      sw[0] = 1'b1;
      step(5); chk("btn_edge5", int'(ifa.BTN_STATE[0]), 0);
      step(1); chk("btn_edge6", int'(ifa.BTN_STATE[0]), 1);
      step(24);
      chk_log("hold_up_a", 0, 4, '{7, 17, 22, 27}, '{0, 0, 0, 0});
      chk_log("hold_up_b", 1, 1, '{7, 0, 0, 0}, '{0, 0, 0, 0});
      sw[0] = 1'b0; step(12);

      // 3: Left and Down together -> Down wins, single pulse
      pulse_reset(); start();
      sw[1] = 1'b1; sw[2] = 1'b1; step(8); sw = '0; step(12);
      chk_log("prio_a", 0, 1, '{7, 0, 0, 0}, '{1, 0, 0, 0});

      // 4: Right held, Up pressed mid-hold, Right released -> Up after IDLE
      pulse_reset(); start();
      sw[3] = 1'b1; step(7);
      sw[0] = 1'b1; step(4);
      sw[3] = 1'b0; step(8);
      sw[0] = 1'b0; step(21);
      chk_log("handoff_a", 0, 3, '{7, 17, 19, 0}, '{3, 3, 0, 0});
      chk_log("handoff_b", 1, 2, '{7, 19, 0, 0}, '{3, 0, 0, 0});

      // 5: reset mid-hold of Down -> re-debounce, fresh pulse
      pulse_reset(); start();
      sw[1] = 1'b1; step(14);
      RST = 1'b1; step(1);
      chk("rst_move_a", int'(mv_a), 0);
      chk("rst_btn_a", int'(ifa.BTN_STATE), 0);
      RST = 1'b0; step(9);
      sw[1] = 1'b0; step(16);
      chk_log("midrst_a", 0, 2, '{7, 22, 0, 0}, '{1, 1, 0, 0});

      // 6: repeat disabled -> one Left only over 40 cycles
      pulse_reset(); start();
      sw[2] = 1'b1; step(40);
      chk_log("norep_b", 1, 1, '{7, 0, 0, 0}, '{2, 0, 0, 0});
      sw[2] = 1'b0; step(12);

      // random: glitchy phase then long-hold phase, occasional resets
      pulse_reset();
      for (int c = 0; c < 4000; c++) begin
         int thr;
         thr = (c < 2000) ? 12 : 2;
         for (int i = 0; i < 4; i++)
            if ($urandom_range(0, 99) < thr) sw[i] = ~sw[i];
         RST = ($urandom_range(0, 399) == 0);
         step(1);
      end
      RST = 1'b0; sw = '0; step(30);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
